// File: rtl/drfm_pkg.sv
// Shared DRFM definitions: mode codes seen by the seven-segment driver,
// the Q4.4 unity scale constant, and the parameter bundle type.
package drfm_pkg;

    localparam int STATE_W = 4;
    localparam int PARAM_W = 8;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'b0000;
    localparam logic [STATE_W-1:0] ST_DELAY   = 4'b0001;
    localparam logic [STATE_W-1:0] ST_SCALE   = 4'b0010;
    localparam logic [STATE_W-1:0] ST_LOAD    = 4'b0100;
    localparam logic [STATE_W-1:0] ST_DOPPLER = 4'b1000;
    localparam logic [STATE_W-1:0] ST_ERR     = 4'b1111;

    localparam logic [PARAM_W-1:0] SCALE_UNITY_Q44 = 8'h10;

    typedef struct packed {
        logic [PARAM_W-1:0] delay;
        logic [PARAM_W-1:0] scale;
        logic [PARAM_W-1:0] doppler;
    } drfm_params_t;

    localparam drfm_params_t PARAMS_RESET = '{
        delay:   8'h00,
        scale:   SCALE_UNITY_Q44,
        doppler: 8'h00
    };

    // Bits needed for a counter running 0..limit-1, never narrower than one bit.
    function automatic int counter_width(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/drfm_mode_ctrl_if.sv
// Front-panel / capture-memory bundle of the DRFM mode controller.
interface drfm_mode_ctrl_if;
    import drfm_pkg::*;

    logic               btn_n;
    logic [PARAM_W-1:0] sw;
    logic               load_done;
    logic [STATE_W-1:0] state;
    logic               load_start;
    logic [PARAM_W-1:0] delay_val;
    logic [PARAM_W-1:0] scale_val;
    logic [PARAM_W-1:0] doppler_val;
    logic               run;

    modport master (
        output btn_n, sw, load_done,
        input  state, load_start, delay_val, scale_val, doppler_val, run
    );

    modport slave (
        input  btn_n, sw, load_done,
        output state, load_start, delay_val, scale_val, doppler_val, run
    );

endinterface

// File: rtl/drfm_mode_ctrl_btn_debounce.sv
// Pushbutton conditioning: 2-FF synchroniser, level debouncer and a
// single-cycle press pulse on each accepted 1->0 transition.
module btn_debounce
    import drfm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // A new level is taken only after DEBOUNCE_CYCLES consecutive samples
    // disagreeing with the current one; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/drfm_mode_ctrl.sv
// DRFM front-panel mode controller: steps the operator through sample load
// and delay/scale/doppler entry, latching each parameter from the switches.
module drfm_mode_ctrl
    import drfm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOAD_TIMEOUT    = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    drfm_mode_ctrl_if.slave   bus
);

    localparam int TW = counter_width(LOAD_TIMEOUT);
    localparam logic [TW-1:0] TCNT_LAST = TW'(LOAD_TIMEOUT - 1);

    logic               press;
    logic [STATE_W-1:0] state_q;
    logic               load_start_q;
    logic               run_q;
    drfm_params_t       params_q;
    logic [TW-1:0]      tcnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (bus.btn_n),
        .press (press)
    );

    // load_done is checked before the timeout so a completion arriving on the
    // final allowed cycle still counts as a successful load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            load_start_q <= 1'b0;
            run_q        <= 1'b0;
            params_q     <= PARAMS_RESET;
            tcnt         <= '0;
        end else begin
            load_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        state_q      <= ST_LOAD;
                        load_start_q <= 1'b1;
                        run_q        <= 1'b0;
                        tcnt         <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_done) begin
                        state_q <= ST_DELAY;
                    end else if (tcnt == TCNT_LAST) begin
                        state_q <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_DELAY: begin
                    if (press) begin
                        params_q.delay <= bus.sw;
                        state_q        <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    if (press) begin
                        params_q.scale <= bus.sw;
                        state_q        <= ST_DOPPLER;
                    end
                end
                ST_DOPPLER: begin
                    if (press) begin
                        params_q.doppler <= bus.sw;
                        state_q          <= ST_IDLE;
                        run_q            <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (press) begin
                        state_q <= ST_IDLE;
                        run_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.load_start  = load_start_q;
    assign bus.run         = run_q;
    assign bus.delay_val   = params_q.delay;
    assign bus.scale_val   = params_q.scale;
    assign bus.doppler_val = params_q.doppler;

endmodule

// File: doc/drfm_mode_ctrl.md
DRFM_MODE_CTRL -- requirements
Module: drfm_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: stable-input cycles required to accept a button level change (10 ms at 50 MHz).
REQ-002 Parameter LOAD_TIMEOUT, default 1048576: maximum cycles spent in LOAD waiting for load_done.
REQ-003 clk  input  1  single system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 btn_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncing.
REQ-006 sw  input  8  parameter switches, quasi-static.
REQ-007 load_done  input  1  one-cycle pulse from the capture memory when the sample load completes.
REQ-008 state  output  4  mode code for the seven-segment driver: IDLE 4'b0000, DELAY 4'b0001, SCALE 4'b0010, LOAD 4'b0100, DOPPLER 4'b1000, ERR 4'b1111.
REQ-009 load_start  output  1  one-cycle pulse requesting a sample load.
REQ-010 delay_val, scale_val, doppler_val  output  8 each  latched DRFM parameters.
REQ-011 run  output  1  high when a complete configuration is active.

Function
REQ-012 btn_n SHALL pass through a 2-FF synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-013 A press SHALL be a single-cycle pulse on the debounced 1->0 transition; holding the button SHALL NOT repeat it.
REQ-014 The FSM states are IDLE, LOAD, DELAY, SCALE, DOPPLER, ERR; state SHALL be a registered output equal to the current state's code.
REQ-015 IDLE + press -> LOAD; run cleared the same edge; load_start high for exactly the first cycle in LOAD.
REQ-016 LOAD: a timeout counter starts at 0 on entry and increments each cycle; load_done -> DELAY; counter reaching LOAD_TIMEOUT-1 without load_done -> ERR.
REQ-017 load_done in the same cycle as timeout expiry SHALL win (-> DELAY).
REQ-018 Presses in LOAD SHALL be ignored; load_done outside LOAD SHALL be ignored.
REQ-019 DELAY + press: delay_val <= sw, -> SCALE.
REQ-020 SCALE + press: scale_val <= sw, -> DOPPLER.
REQ-021 DOPPLER + press: doppler_val <= sw, -> IDLE, run <= 1.
REQ-022 ERR + press -> IDLE with run = 0; parameter registers keep their values.
REQ-023 Parameter registers SHALL change only on the press edge in their own state; sw changes at any other time SHALL have no effect.
REQ-024 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025 While rst_n = 0 at a clock edge: state IDLE (4'b0000), load_start 0, run 0, delay_val 8'h00, scale_val 8'h10 (unity, Q4.4), doppler_val 8'h00, timeout and debounce counters 0, debounced button level 1.
REQ-026 A reset asserted mid-operation, including in LOAD, SHALL abort without issuing load_start; outputs take reset values on that edge.

Structure
REQ-027 State codes and the Q4.4 unity constant SHALL live in shared package drfm_pkg, which the display driver also uses.
REQ-028 Synchroniser plus debouncer plus edge detect SHALL be a sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n, press).

Verification (DEBOUNCE_CYCLES=4, LOAD_TIMEOUT=16)
REQ-029 Happy path: press; load_done 5 cycles after load_start; presses with sw=8'h22, 8'h18, 8'h05 -> state sequence 0000,0100,0001,0010,1000,0000; delay_val=22, scale_val=18, doppler_val=05; run=1.
REQ-030 Timeout: press, withhold load_done -> state=4'b1111 exactly 16 cycles after entering LOAD; press -> 0000, run=0, parameters unchanged.
REQ-031 Bounce: btn_n toggles every 2 cycles for 20 cycles, then held low for 10 cycles -> exactly one press, one load_start pulse.
REQ-032 Race: load_done asserted on the 16th LOAD cycle -> DELAY, not ERR.
REQ-033 Reset in LOAD on cycle 3 -> state 0000, scale_val 8'h10, no further load_start; later load_done pulses ignored.
REQ-034 Ignore: extra presses and sw changes during LOAD -> no state change and no parameter change.
